// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control unit (master) and multicycle_alu (slave).
interface multicycle_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       func;
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             isZero;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, func, read_data1, read_data2,
        input  ready, done, result, isZero, overflow, illegal
    );

    modport slave (
        input  start, func, read_data1, read_data2,
        output ready, done, result, isZero, overflow, illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU: 1-cycle logic/arith/compare/shift ops; iterative MUL/DIV/REM
// (WIDTH+1 cycle latency) is built only when ALU_MULDIV_EN is defined.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    multicycle_alu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] F_ADD  = 4'h0;
    localparam logic [3:0] F_SUB  = 4'h1;
    localparam logic [3:0] F_AND  = 4'h2;
    localparam logic [3:0] F_OR   = 4'h3;
    localparam logic [3:0] F_XOR  = 4'h4;
    localparam logic [3:0] F_NOR  = 4'h5;
    localparam logic [3:0] F_SLT  = 4'h6;
    localparam logic [3:0] F_SLTU = 4'h7;
    localparam logic [3:0] F_SLL  = 4'h8;
    localparam logic [3:0] F_SRL  = 4'h9;
    localparam logic [3:0] F_SRA  = 4'hA;

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] F_MUL  = 4'hB;
    localparam logic [3:0] F_DIV  = 4'hC;
    localparam logic [3:0] F_REM  = 4'hD;
    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, EXEC = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             is_zero_q, is_zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] op_a, op_b, sum, diff, sc_res;
    logic [SHW-1:0]   sh_amt;
    logic             sc_ovf, sc_ill;

    assign op_a   = bus.read_data1;
    assign op_b   = bus.read_data2;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign sh_amt = op_b[SHW-1:0];

`ifdef ALU_MULDIV_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       md_op_q, md_op_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    // acc: product / partial remainder; opa: multiplicand / dividend->quotient; opb: multiplier / divisor
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic [WIDTH-1:0] step_acc, step_opa, step_opb, quo_fix, rem_fix, md_res;
    logic             is_muldiv_c;

    assign is_muldiv_c = (bus.func == F_MUL) || (bus.func == F_DIV) || (bus.func == F_REM);

    // One shift-add or restoring shift-subtract step, plus sign fix-up of that step's result
    always_comb begin : muldiv_step
        rem_shift = {acc_q, opa_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opb_q};
        step_acc  = acc_q;
        step_opa  = opa_q;
        step_opb  = opb_q;
        if (md_op_q == OP_MUL) begin
            if (opb_q[0]) begin
                step_acc = acc_q + opa_q;
            end
            step_opa = opa_q << 1;
            step_opb = opb_q >> 1;
        end else if (!rem_diff[WIDTH]) begin
            step_acc = rem_diff[WIDTH-1:0];
            step_opa = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = rem_shift[WIDTH-1:0];
            step_opa = {opa_q[WIDTH-2:0], 1'b0};
        end
        quo_fix = (a_neg_q ^ b_neg_q) ? -step_opa : step_opa;
        rem_fix = a_neg_q ? -step_acc : step_acc;
        // Divide by zero leaves |dividend| as remainder, so only the quotient needs forcing
        case (md_op_q)
            OP_MUL:  md_res = step_acc;
            OP_DIV:  md_res = (opb_q == '0) ? '1 : quo_fix;
            default: md_res = rem_fix;
        endcase
    end
`endif

    always_comb begin : single_cycle_op
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (bus.func)
            F_ADD: begin
                sc_res = sum;
                sc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            F_SUB: begin
                sc_res = diff;
                sc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            F_AND:   sc_res = op_a & op_b;
            F_OR:    sc_res = op_a | op_b;
            F_XOR:   sc_res = op_a ^ op_b;
            F_NOR:   sc_res = ~(op_a | op_b);
            F_SLT:   sc_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            F_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            F_SLL:   sc_res = op_a << sh_amt;
            F_SRL:   sc_res = op_a >> sh_amt;
            F_SRA:   sc_res = $unsigned($signed(op_a) >>> sh_amt);
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin : fsm_next
        state_d    = state_q;
        done_d     = 1'b0;
        result_d   = result_q;
        is_zero_d  = is_zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
`ifdef ALU_MULDIV_EN
        cnt_d      = cnt_q;
        md_op_d    = md_op_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
`ifdef ALU_MULDIV_EN
                    if (is_muldiv_c) begin
                        state_d = EXEC;
                        cnt_d   = '0;
                        acc_d   = '0;
                        a_neg_d = op_a[WIDTH-1];
                        b_neg_d = op_b[WIDTH-1];
                        if (bus.func == F_MUL) begin
                            md_op_d = OP_MUL;
                            opa_d   = op_a;
                            opb_d   = op_b;
                        end else begin
                            md_op_d = (bus.func == F_DIV) ? OP_DIV : OP_REM;
                            opa_d   = op_a[WIDTH-1] ? -op_a : op_a;
                            opb_d   = op_b[WIDTH-1] ? -op_b : op_b;
                        end
                    end else
`endif
                    begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        result_d   = sc_res;
                        is_zero_d  = (sc_res == '0);
                        overflow_d = sc_ovf;
                        illegal_d  = sc_ill;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            EXEC: begin
                cnt_d = cnt_q + SHW'(1);
                acc_d = step_acc;
                opa_d = step_opa;
                opb_d = step_opb;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    result_d   = md_res;
                    is_zero_d  = (md_res == '0);
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef ALU_MULDIV_EN
        ready_d = (state_d != EXEC);
`else
        ready_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            is_zero_q  <= 1'b1;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_q      <= '0;
            md_op_q    <= OP_MUL;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            result_q   <= result_d;
            is_zero_q  <= is_zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
`ifdef ALU_MULDIV_EN
            cnt_q      <= cnt_d;
            md_op_q    <= md_op_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
`endif
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.isZero   = is_zero_q;
    assign bus.overflow = overflow_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed, table-driven bench for multicycle_alu (WIDTH=32); mul/div sequences
// are exercised when ALU_MULDIV_EN is defined, otherwise B/C/D are expected illegal.
module tb_multicycle_alu;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_alu_if #(.WIDTH(W)) bus ();
    multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   func;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         ill;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic o, input logic il);
        vec_t v;
        v.func = f; v.a = a; v.b = b; v.res = r; v.ovf = o; v.ill = il;
        return v;
    endfunction

    task automatic drive(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start      = 1'b1;
        bus.func       = f;
        bus.read_data1 = a;
        bus.read_data2 = b;
    endtask

    task automatic check_out(input string nm, input logic d, input logic [W-1:0] r,
                             input logic o, input logic il);
        chk({nm, " done"},     W'(bus.done),     W'(d));
        chk({nm, " result"},   bus.result,       r);
        chk({nm, " isZero"},   W'(bus.isZero),   W'(r == '0));
        chk({nm, " overflow"}, W'(bus.overflow), W'(o));
        chk({nm, " illegal"},  W'(bus.illegal),  W'(il));
    endtask

`ifdef ALU_MULDIV_EN
    task automatic run_md(input string nm, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input bit busy_probe);
        int lat;
        bit busy_ok;
        bit seen;
        drive(f, a, b);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the op in flight must not see them
        bus.start      = 1'b0;
        bus.func       = 4'h0;
        bus.read_data1 = ~a;
        bus.read_data2 = a;
        lat = 1; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && lat < 45) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.ready) busy_ok = 1'b0;
                bus.start = busy_probe && (lat == 5);
                @(posedge clk); #1;
                lat++;
            end
        end
        bus.start = 1'b0;
        chk({nm, " latency"}, W'(lat), W'(W + 1));
        chk({nm, " ready low while busy"}, W'(busy_ok), W'(1));
        chk({nm, " ready at done"}, W'(bus.ready), W'(1));
        check_out(nm, 1'b1, exp, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk({nm, " done one cycle"}, W'(bus.done), W'(0));
        chk({nm, " result held"}, bus.result, exp);
    endtask
`endif

    initial begin
        bit seen;
        bus.start = 1'b0; bus.func = 4'h0; bus.read_data1 = '0; bus.read_data2 = '0;

        vecs.push_back(mk(4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0));
        vecs.push_back(mk(4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0));
        vecs.push_back(mk(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0));
        vecs.push_back(mk(4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0));
        vecs.push_back(mk(4'h5, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mk(4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mk(4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'h6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'hA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'h8, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0));
        vecs.push_back(mk(4'h9, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'hA, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 1'b0, 1'b0));
        vecs.push_back(mk(4'hE, 32'h00000123, 32'h00000456, 32'h00000000, 1'b0, 1'b1));
        vecs.push_back(mk(4'h2, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mk(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1));
`ifndef ALU_MULDIV_EN
        vecs.push_back(mk(4'hB, 32'h00000003, 32'h00000007, 32'h00000000, 1'b0, 1'b1));
        vecs.push_back(mk(4'hC, 32'h00000009, 32'h00000002, 32'h00000000, 1'b0, 1'b1));
        vecs.push_back(mk(4'hD, 32'h00000009, 32'h00000002, 32'h00000000, 1'b0, 1'b1));
`endif

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset ready", W'(bus.ready), W'(1));
        check_out("reset", 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("idle no done", W'(bus.done), W'(0));

        // Back-to-back single-cycle ops: one result every cycle
        foreach (vecs[i]) begin
            drive(vecs[i].func, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            chk($sformatf("v%0d ready", i), W'(bus.ready), W'(1));
            check_out($sformatf("v%0d", i), 1'b1, vecs[i].res, vecs[i].ovf, vecs[i].ill);
        end
        bus.start = 1'b0;
        bus.read_data1 = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("done drops", W'(bus.done), W'(0));
        chk("result held", bus.result, vecs[vecs.size() - 1].res);
        chk("illegal held", W'(bus.illegal), W'(vecs[vecs.size() - 1].ill));

`ifdef ALU_MULDIV_EN
        run_md("mul neg", 4'hB, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b1);
        run_md("mul zero", 4'hB, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0);
        run_md("div -7/2", 4'hC, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
        run_md("rem -7%2", 4'hD, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        run_md("div 9/0", 4'hC, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        run_md("rem 9%0", 4'hD, 32'h00000009, 32'h00000000, 32'h00000009, 1'b0);
        run_md("div min/-1", 4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_md("rem min%-1", 4'hD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_md("div 100/7", 4'hC, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0);
        run_md("div 7/-2", 4'hC, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        run_md("rem 7%-2", 4'hD, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0);
`endif

        // Async reset with non-reset outputs (and, with mul/div, an op in flight)
        drive(4'h0, 32'h7FFFFFFF, 32'h00000001);
        @(posedge clk); #1;
        chk("pre-reset result", bus.result, 32'h80000000);
        chk("pre-reset overflow", W'(bus.overflow), W'(1));
        bus.start = 1'b0;
`ifdef ALU_MULDIV_EN
        drive(4'hC, 32'h00000064, 32'h00000007);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid-div ready", W'(bus.ready), W'(0));
`endif
        reset = 1'b1;
        #1;
        chk("abort ready", W'(bus.ready), W'(1));
        check_out("abort", 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        chk("no done after abort", W'(seen), W'(0));
        chk("result stays reset", bus.result, '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered ALU that replaces the single-cycle combinational ALU in the datapath. It accepts one operation per `start` pulse and computes single-cycle logic, arithmetic, compare and shift ops with one cycle of latency. Iterative multiply/divide/remainder ops take WIDTH+1 cycles, with a ready/done handshake that the control unit uses to stall the pipeline.

## Interface
- `WIDTH`, 32: operand/result width; ≥ 4, power of two.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted only when `ready`=1.
- `func` in 4: operation code, sampled with `start`.
- `read_data1` in WIDTH: operand A, sampled with `start`.
- `read_data2` in WIDTH: operand B / shift amount, sampled with `start`.
- `ready` out 1: idle, can accept `start`.
- `done` out 1: one-cycle pulse; `result` and flags valid and held until next `done`.
- `result` out WIDTH: registered result.
- `isZero` out 1: registered, `result`==0.
- `overflow` out 1: signed overflow of ADD/SUB; 0 for all other ops.
- `illegal` out 1: `func` unsupported; `result`=0.

## Operation
- Func codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, A SRA; shift amount is `read_data2[$clog2(WIDTH)-1:0]`.
  - B MUL (low WIDTH bits, signed/unsigned identical), C DIV (signed quotient), D REM (signed remainder).
  - E, F illegal.
- FSM states: IDLE, EXEC, DONE.
  - IDLE, `start`=0: stay in IDLE.
  - IDLE, `start`=1, single-cycle or illegal op: compute, register outputs, go to DONE.
  - IDLE, `start`=1, op B/C/D: latch operands, clear iteration counter, go to EXEC.
  - EXEC: one shift-add (MUL) or restoring shift-subtract step (DIV/REM) on absolute values per cycle. After WIDTH steps, apply sign correction, register outputs, go to DONE.
  - DONE: `done`=1 for this cycle only; go to IDLE.
- `ready`=1 in IDLE and DONE. A `start` seen in DONE is accepted exactly as in IDLE, so back-to-back single-cycle ops issue every cycle.
- `start` while `ready`=0 is ignored; no queuing.
- Operands and `func` are captured at acceptance. Later input changes do not affect the operation in flight.
- Divide boundaries:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Most-negative ÷ −1: quotient = dividend, remainder = 0.
  - Remainder takes the dividend's sign.
- `overflow` = (A and B signs equal for ADD, or differ for SUB) and result sign differs from A.
- `result`, `isZero`, `overflow` and `illegal` update only on the cycle `done` rises. Otherwise they hold.

## Timing
- Reset (async assert, sync release):
  - State = IDLE, `ready`=1, `done`=0.
  - `result`=0, `isZero`=1, `overflow`=0, `illegal`=0.
  - Iteration counter = 0.
- Single-cycle op accepted at edge T: `done`=1 and result valid after edge T+1.
- Mul/div accepted at edge T:
  - `ready`=0 from T+1 through T+WIDTH.
  - `done`=1 after edge T+WIDTH+1, i.e. latency WIDTH+1.
- Reset during EXEC aborts the operation immediately. No `done` is produced and outputs take their reset values.
- Illegal op: 1-cycle latency like a single-cycle op, `illegal`=1 and `result`=0.

## Configuration
- `ALU_MULDIV_EN` defined: the multiply/divide datapath, EXEC state and iteration counter are compiled in, and codes B/C/D behave as above.
- `ALU_MULDIV_EN` undefined: no mul/div logic is built. Codes B/C/D are treated as illegal (1-cycle, `illegal`=1, `result`=0), and `ready` never deasserts.

## Test plan
- Reset with WIDTH=32 -> `ready`=1, `done`=0, `result`=0, `isZero`=1, all flags 0. Assert reset mid-DIV -> same values, no `done` pulse.
- ADD 0x7FFFFFFF+1 -> `result`=0x80000000, `overflow`=1 one cycle after start. Next cycle SUB 5−5 -> `result`=0, `isZero`=1, `done` on consecutive cycles.
- SLT 0xFFFFFFFF,1 -> 1 and SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000. SLL by 33 uses the low 5 bits -> shift by 1.
- MUL 0xFFFFFFFD×7 -> 0xFFFFFFEB. Check `done` exactly 33 cycles after start, `ready`=0 throughout, and a `start` pulsed while busy is ignored.
- DIV −7÷2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. DIV 9÷0 -> 0xFFFFFFFF and REM -> 9. DIV 0x80000000÷−1 -> 0x80000000.
- func=0xE -> `illegal`=1, `result`=0, `done` after 1 cycle. With `ALU_MULDIV_EN` undefined, func=0xB gives the same response.
